imem_fetch: RTL and testbench

//  Instruction fetch unit: the read-side initiator for the combinational instruction ROM (6-bit word addr -> 32-bit word).

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/imem_fetch.sv | 129 ++++++++++++
 tb/tb_imem_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (RUN, HALT, FAULT)
//   fetch_entry_t : one buffered fetch, instruction word plus its byte PC
//   EBREAK / NOP  : instruction encodings the fetch unit cares about
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int XLEN    = 64;

   localparam logic [INSTR_W-1:0] EBREAK = 32'h0010_0073;
   localparam logic [INSTR_W-1:0] NOP    = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [XLEN-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch_entry_t between fetch and decode.
// Ports:
//   clk      in   clock
//   reset_n  in   synchronous reset, active-low (empties the buffer)
//   push     in   write wdata at the tail
//   pop      in   drop the head entry
//   flush    in   discard all entries; overrides push and pop
//   wdata    in   entry to write
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   head     out  oldest entry (meaningless while empty)
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PTR_W'(1);
         if (pop)  rd_q <= rd_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: an entry is only observed after it is written.
   always_ff @(posedge clk) begin
      if (reset_n && push && !flush) mem_q[wr_q] <= wdata;
   end

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch unit in front of a combinational instruction ROM.
// Holds the PC, fetches one word per cycle into a small FIFO and hands the
// head entry to decode over valid/ready. Handles redirects, ebreak halt and
// resume, and faults on misaligned or out-of-ROM fetch addresses.
// Ports:
//   clk            in   clock
//   reset_n        in   synchronous reset, active-low
//   imem_addr      out  ROM word address = pc[ADDR_W+1:2]
//   imem_q         in   ROM data for imem_addr (combinational)
//   redirect_valid in   one-cycle redirect request
//   redirect_pc    in   redirect target byte address
//   resume         in   one-cycle pulse leaving HALT
//   out_valid      out  head entry valid
//   out_ready      in   decode takes the head this cycle
//   out_instr      out  head instruction (0 when empty)
//   out_pc         out  head byte PC (0 when empty)
//   halted         out  FSM in HALT
//   fault          out  FSM in FAULT
module imem_fetch
   import fetch_pkg::*;
#(
   parameter int               N        = INSTR_W,
   parameter int               PC_W     = XLEN,
   parameter int               ADDR_W   = 6,
   parameter logic [PC_W-1:0]  RESET_PC = '0,
   parameter int               DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [N-1:0]      imem_q,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              resume,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic              halted,
   output logic              fault
);

   // state | meaning
   // RUN   | fetching one word per cycle whenever the FIFO has room
   // HALT  | ebreak was fetched; no fetch until resume or redirect
   // FAULT | PC misaligned or outside the ROM; sticky until redirect or reset

   fetch_state_t state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic halted_q, fault_q;

   logic         fifo_full, fifo_empty;
   logic         pop, space, pc_bad, fetch_slot, push;
   fetch_entry_t fifo_head, push_entry;

   assign imem_addr = pc_q[ADDR_W+1:2];

   assign pop    = !fifo_empty && out_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign space  = !fifo_full || pop;
   assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q[PC_W-1:ADDR_W+2] != '0);

   // Redirect owns the cycle: it flushes and nothing is fetched alongside it.
   assign fetch_slot = (state_q == RUN) && !redirect_valid && space;
   assign push       = fetch_slot && !pc_bad;

   assign push_entry = '{instr: imem_q, pc: pc_q};

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (fetch_slot) begin
                  if (pc_bad) begin
                     state_d = FAULT;
                  end else begin
                     pc_d = pc_q + PC_W'(4);
                     if (imem_q == EBREAK) state_d = HALT;
                  end
               end
            end
            HALT:    if (resume) state_d = RUN;
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q     <= RESET_PC;
         state_q  <= RUN;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         halted_q <= (state_d == HALT);
         fault_q  <= (state_d == FAULT);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wdata   (push_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   // Outputs read as zero while empty so reset presents clean values.
   assign out_valid = !fifo_empty;
   assign out_instr = fifo_empty ? '0 : fifo_head.instr;
   assign out_pc    = fifo_empty ? '0 : fifo_head.pc;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;
   import fetch_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset_n;
   logic [5:0]  imem_addr;
   logic [31:0] imem_q;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        resume;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        halted;
   logic        fault;

   imem_fetch dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .resume         (resume),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] rom [64];
   assign imem_q = rom[imem_addr];

   int checks = 0;
   int errors = 0;

   // Reference model: PC, mode and an ordered queue of pending fetches.
   logic [63:0]  m_pc;
   fetch_state_t m_st;
   fetch_entry_t m_q [$];

   logic [104:0] dut_vec;
   assign dut_vec = {out_valid, out_instr, out_pc, halted, fault, imem_addr};

   function automatic logic [104:0] model_out();
      logic        v;
      logic [31:0] ins;
      logic [63:0] p;
      v   = (m_q.size() > 0);
      ins = v ? m_q[0].instr : 32'h0;
      p   = v ? m_q[0].pc : 64'h0;
      return {v, ins, p, (m_st == HALT), (m_st == FAULT), m_pc[7:2]};
   endfunction

   task automatic model_update(input logic rn, rv, input logic [63:0] rpc,
                               input logic res, rdy);
      logic         popping, room;
      fetch_entry_t e;
      if (!rn) begin
         m_pc = 64'h0;
         m_st = RUN;
         m_q.delete();
      end else if (rv) begin
         m_q.delete();
         m_pc = rpc;
         m_st = RUN;
      end else begin
         popping = (m_q.size() > 0) && rdy;
         room    = (m_q.size() < DEPTH) || popping;
         if (popping) void'(m_q.pop_front());
         if (m_st == RUN && room) begin
            if ((m_pc % 4) != 0 || m_pc >= 64'd256) begin
               m_st = FAULT;
            end else begin
               e.instr = rom[m_pc / 4];
               e.pc    = m_pc;
               m_q.push_back(e);
               m_pc = m_pc + 64'd4;
               if (e.instr == EBREAK) m_st = HALT;
            end
         end else if (m_st == HALT && res) begin
            m_st = RUN;
         end
      end
   endtask

   task automatic tick(input logic rn, rv, input logic [63:0] rpc,
                       input logic res, rdy);
      reset_n        = rn;
      redirect_valid = rv;
      redirect_pc    = rpc;
      resume         = res;
      out_ready      = rdy;
      @(posedge clk);
      model_update(rn, rv, rpc, res, rdy);
      @(negedge clk);
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== {1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 6'h0}) begin
         errors++;
         $display("FAIL reset_values got %h want %h", dut_vec,
                  {1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 6'h0});
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== rom[i]) begin
            errors++;
            $display("FAIL reset_stream[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                     i, out_valid, out_pc, out_instr, 64'(4 * i), rom[i]);
         end
         checks++;
         if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL reset_model[%0d] got %h want %h", i, dut_vec, model_out());
         end
      end
   endtask

   task automatic test_backpressure();
      tick(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== rom[0]) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%b pc=%h ins=%h want v=1 pc=0 ins=%h",
                     i, out_valid, out_pc, out_instr, rom[0]);
         end
      end
      checks++;
      if (imem_addr !== 6'd2) begin
         errors++;
         $display("FAIL bp_pc_hold got addr=%0d want 2", imem_addr);
      end
      for (int i = 1; i <= 2; i++) begin
         tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * i)) begin
            errors++;
            $display("FAIL bp_release[%0d] got v=%b pc=%h want v=1 pc=%h",
                     i, out_valid, out_pc, 64'(4 * i));
         end
         checks++;
         if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL bp_model[%0d] got %h want %h", i, dut_vec, model_out());
         end
      end
   endtask

   task automatic test_redirect();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 64'h98, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_flush got v=%b want v=0", out_valid);
      end
      tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h98 || out_instr !== 32'hfd01_0113) begin
         errors++;
         $display("FAIL redir_target got v=%b pc=%h ins=%h want v=1 pc=98 ins=fd010113",
                  out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_halt_resume();
      bit seen_eb = 0;
      bit done    = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
         if (out_valid && out_pc == 64'hb8 && out_instr == EBREAK) seen_eb = 1;
         checks++;
         if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL halt_model[%0d] got %h want %h", i, dut_vec, model_out());
         end
         if (halted === 1'b1 && out_valid === 1'b0) done = 1;
      end
      checks++;
      if (!done || !seen_eb) begin
         errors++;
         $display("FAIL halt_reach got done=%0d ebreak_seen=%0d want 1 1", done, seen_eb);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 6'd47) begin
            errors++;
            $display("FAIL halt_hold[%0d] got v=%b h=%b addr=%0d want v=0 h=1 addr=47",
                     i, out_valid, halted, imem_addr);
         end
      end
      tick(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
      done = 0;
      for (int i = 0; i < 4 && !done; i++) begin
         if (out_valid === 1'b1) done = 1;
         else tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      end
      checks++;
      if (!done || out_pc !== 64'hbc || halted !== 1'b0) begin
         errors++;
         $display("FAIL resume_next got v=%b pc=%h h=%b want v=1 pc=bc h=0",
                  out_valid, out_pc, halted);
      end
   endtask

   task automatic test_fault();
      tick(1'b1, 1'b1, 64'h102, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fault_misaligned got f=%b v=%b want f=1 v=0", fault, out_valid);
      end
      tick(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
      checks++;
      if (fault !== 1'b1) begin
         errors++;
         $display("FAIL fault_sticky got f=%b want 1", fault);
      end
      tick(1'b1, 1'b1, 64'h100, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fault_range got f=%b v=%b want f=1 v=0", fault, out_valid);
      end
      tick(1'b1, 1'b1, 64'h1c, 1'b0, 1'b1);
      checks++;
      if (fault !== 1'b0) begin
         errors++;
         $display("FAIL fault_clear got f=%b want 0", fault);
      end
      tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h1c || out_instr !== rom[7]) begin
         errors++;
         $display("FAIL fault_refetch got v=%b pc=%h ins=%h want v=1 pc=1c ins=%h",
                  out_valid, out_pc, out_instr, rom[7]);
      end
   endtask

   task automatic test_reset_midstream();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
         tick(1'b0, (pass == 1), 64'h40, 1'b0, 1'b0);
         checks++;
         if (dut_vec !== {1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 6'h0}) begin
            errors++;
            $display("FAIL mid_reset[%0d] got %h want %h", pass, dut_vec,
                     {1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 6'h0});
         end
         tick(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            errors++;
            $display("FAIL mid_restart[%0d] got v=%b pc=%h want v=1 pc=0",
                     pass, out_valid, out_pc);
         end
      end
   endtask

   task automatic test_random();
      logic        rn, rv, res, rdy;
      logic [63:0] rpc;
      int          r;
      tick(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         rn  = ($urandom_range(0, 99) != 0);
         rv  = ($urandom_range(0, 9) == 0);
         res = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         r   = $urandom_range(0, 9);
         if (r < 7)       rpc = {56'h0, 6'($urandom_range(0, 63)), 2'b00};
         else if (r == 7) rpc = {56'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
         else if (r == 8) rpc = 64'h100 + {54'h0, 8'($urandom_range(0, 255)), 2'b00};
         else             rpc = {$urandom, $urandom};
         tick(rn, rv, rpc, res, rdy);
         checks++;
         if (dut_vec !== model_out()) begin
            errors++;
            $display("FAIL rand_model[%0d] got %h want %h", i, dut_vec, model_out());
         end
      end
   endtask

   initial begin
      logic [31:0] w;
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      resume         = 1'b0;
      out_ready      = 1'b1;
      m_pc           = 64'h0;
      m_st           = RUN;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         if (w == EBREAK) w = NOP;
         rom[i] = w;
      end
      rom[38] = 32'hfd01_0113;
      rom[46] = EBREAK;

      test_reset();
      test_backpressure();
      test_redirect();
      test_halt_resume();
      test_fault();
      test_reset_midstream();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
